// File: rtl/prog_loader_pkg.sv
// Shared constants for the serial program loader: state codes and defaults.
// Optional trailing checksum byte is enabled with PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

    localparam int IMEM_ADDR_W = 14;
    localparam int DEF_ADDR_W  = IMEM_ADDR_W;
    localparam int DEF_TIMEOUT = 2_000_000;
    localparam int DEF_TO_W    = 21;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;
    localparam logic [2:0] S_CSUM   = 3'd7;

    // A frame may fill the memory exactly but never exceed it.
    function automatic logic len_too_big(input logic [15:0] n,
                                         input int aw);
        return {16'd0, n} > (32'd1 << aw);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write/status bundle of the loader.
// Build option PROG_LOADER_CHECKSUM_EN does not change this interface.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output start, rx_valid, rx_data,
        input  imem_we, imem_addr, imem_wdata,
        input  cpu_hold, busy, done, error, words_loaded
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output imem_we, imem_addr, imem_wdata,
        output cpu_hold, busy, done, error, words_loaded
    );
endinterface

// File: rtl/prog_loader_timeout.sv
// Idle-gap counter: clears on demand, counts while run, saturates at limit.
// Used identically with or without PROG_LOADER_CHECKSUM_EN.
module prog_loader_timeout
    import prog_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
    parameter int TO_W           = DEF_TO_W
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);
    localparam logic [TO_W-1:0] TOP = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || clear)
            cnt <= '0;
        else if (run && cnt != TOP)
            cnt <= cnt + 1'b1;
    end

    assign expire = run && (cnt == TOP);

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: LEN_LO, LEN_HI, N little-endian words -> imem writes.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
    parameter int TO_W           = DEF_TO_W
) (
    input  logic         clock,
    input  logic         reset,
    prog_loader_if.slave bus
);
    logic [2:0]        state, nxt;
    logic [15:0]       len;
    logic [15:0]       n_full;
    logic [1:0]        idx;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   words;
    logic              hold, busy_q, done_q, err_q;
    logic              timed, to_clr, to_exp, last_word;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_FIN = S_CSUM;
    logic [7:0] csum;
`else
    localparam logic [2:0] S_FIN = S_DONE;
`endif

    assign n_full    = {bus.rx_data, len[7:0]};
    assign last_word = (32'(words) + 32'd1) == 32'(len);
    assign timed     = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA)   || (state == S_CSUM);
    assign to_clr    = bus.rx_valid || (state == S_IDLE && bus.start);

    prog_loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (to_clr),
        .run    (timed),
        .expire (to_exp)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:   if (bus.start) nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (bus.rx_valid)  nxt = S_LEN_HI;
                else if (to_exp)   nxt = S_ERR;
            end
            S_LEN_HI: begin
                if (bus.rx_valid) begin
                    if (n_full == 16'd0)                nxt = S_FIN;
                    else if (len_too_big(n_full, ADDR_W)) nxt = S_ERR;
                    else                                nxt = S_DATA;
                end else if (to_exp) begin
                    nxt = S_ERR;
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    if (idx == 2'd3) nxt = S_WRITE;
                end else if (to_exp) begin
                    nxt = S_ERR;
                end
            end
            S_WRITE: begin
                if (bus.rx_valid)   nxt = S_ERR;
                else if (last_word) nxt = S_FIN;
                else                nxt = S_DATA;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (bus.rx_valid)
                    nxt = (bus.rx_data == csum) ? S_DONE : S_ERR;
                else if (to_exp)
                    nxt = S_ERR;
            end
`endif
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            len    <= '0;
            idx    <= '0;
            wdata  <= '0;
            addr   <= '0;
            words  <= '0;
            hold   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= nxt;
            unique case (state)
                S_IDLE: if (bus.start) begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    words  <= '0;
                    busy_q <= 1'b1;
                    hold   <= 1'b1;
                end
                S_LEN_LO: if (bus.rx_valid) len[7:0] <= bus.rx_data;
                S_LEN_HI: if (bus.rx_valid) begin
                    len[15:8] <= bus.rx_data;
                    idx       <= '0;
                    addr      <= '0;
                end
                S_DATA: if (bus.rx_valid) begin
                    wdata[8*idx +: 8] <= bus.rx_data;
                    idx               <= idx + 2'd1;
                end
                S_WRITE: begin
                    words <= words + 1'b1;
                    if (nxt == S_DATA) addr <= addr + 1'b1;
                end
                default: ;
            endcase
            // Status flips on entry so cpu_hold drops the cycle after the last write.
            if (nxt == S_DONE) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
                hold   <= 1'b0;
            end
            if (nxt == S_ERR) begin
                err_q  <= 1'b1;
                busy_q <= 1'b0;
                hold   <= 1'b0;
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset)
            csum <= '0;
        else if (state == S_IDLE && bus.start)
            csum <= '0;
        else if (bus.rx_valid && (state == S_LEN_LO ||
                 state == S_LEN_HI || state == S_DATA))
            csum <= csum ^ bus.rx_data;
    end
`endif

    assign bus.imem_we      = (state == S_WRITE) && !reset;
    assign bus.imem_addr    = addr;
    assign bus.imem_wdata   = wdata;
    assign bus.cpu_hold     = hold;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.error        = err_q;
    assign bus.words_loaded = words;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader (ADDR_W=4, TIMEOUT_CYCLES=100).
// Checksum frames are exercised when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct packed {
        logic        done;
        logic        error;
        logic [AW:0] words;
    } st_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       prev_busy = 1'b0;
    logic [7:0] csum;
    int         checks = 0;
    int         errors = 0;
    wr_t        wr_q[$];
    st_t        st_q[$];

    prog_loader_if #(.ADDR_W(AW)) bus ();

    prog_loader #(
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (100),
        .TO_W           (7)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every write and every end of load is checked against the queues.
    always @(negedge clock) begin
        wr_t ew;
        st_t es;
        if (reset) begin
            prev_busy = 1'b0;
        end else begin
            if (bus.imem_we) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h",
                             bus.imem_addr, bus.imem_wdata);
                end else begin
                    ew = wr_q.pop_front();
                    chk("wr_addr", 64'(bus.imem_addr), 64'(ew.addr));
                    chk("wr_data", 64'(bus.imem_wdata), 64'(ew.data));
                end
            end
            if (prev_busy && !bus.busy) begin
                if (st_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_end: done %0b error %0b",
                             bus.done, bus.error);
                end else begin
                    es = st_q.pop_front();
                    chk("done", 64'(bus.done), 64'(es.done));
                    chk("error", 64'(bus.error), 64'(es.error));
                    chk("words_loaded", 64'(bus.words_loaded), 64'(es.words));
                    chk("cpu_hold_low", 64'(bus.cpu_hold), 64'd0);
                end
            end
            prev_busy = bus.busy;
        end
    end

    task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wr_q.push_back(w);
    endtask

    task automatic push_st(input logic d, input logic e,
                           input logic [AW:0] n);
        st_t s;
        s.done  = d;
        s.error = e;
        s.words = n;
        st_q.push_back(s);
    endtask

    task automatic send_byte(input logic [7:0] v);
        @(negedge clock);
        bus.rx_valid = 1'b1;
        bus.rx_data  = v;
        csum         = csum ^ v;
        @(negedge clock);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic begin_load();
        csum = 8'h00;
        pulse_start();
    endtask

    task automatic end_frame();
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(csum);
`endif
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((st_q.size() != 0 || wr_q.size() != 0) && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: pending st %0d wr %0d want 0",
                     name, st_q.size(), wr_q.size());
            st_q.delete();
            wr_q.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic chk_reset_vals();
        chk("rst_imem_we", 64'(bus.imem_we), 64'd0);
        chk("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
        chk("rst_imem_wdata", 64'(bus.imem_wdata), 64'd0);
        chk("rst_cpu_hold", 64'(bus.cpu_hold), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_error", 64'(bus.error), 64'd0);
        chk("rst_words", 64'(bus.words_loaded), 64'd0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        csum         = 8'h00;
        repeat (3) @(negedge clock);
        chk_reset_vals();
        reset = 1'b0;
        @(negedge clock);
        chk_reset_vals();

        // Two words, with an ignored start pulse in the middle of the frame.
        push_wr(4'd0, 32'h0000_0013);
        push_wr(4'd1, 32'h0010_0093);
        push_st(1'b1, 1'b0, 5'd2);
        begin_load();
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        chk("hold_after_start", 64'(bus.cpu_hold), 64'd1);
        send_byte(8'h02);
        send_byte(8'h00);
        pulse_start();
        send_byte(8'h13); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00);
        send_byte(8'h10); send_byte(8'h00);
        end_frame();
        drain("two_words");

        // Zero-length frame; a byte coinciding with start must be dropped.
        push_st(1'b1, 1'b0, 5'd0);
        csum = 8'h00;
        @(negedge clock);
        bus.start    = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h05;
        @(negedge clock);
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        send_byte(8'h00);
        send_byte(8'h00);
        end_frame();
        drain("zero_len");

        // Stall after one data byte until the idle counter expires.
        push_st(1'b0, 1'b1, 5'd0);
        begin_load();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        drain("timeout");

        // N=17 exceeds a 16-word memory.
        push_st(1'b0, 1'b1, 5'd0);
        begin_load();
        send_byte(8'h11);
        send_byte(8'h00);
        drain("too_long");

        // N=16 fills memory exactly.
        for (int i = 0; i < 16; i++)
            push_wr(AW'(i), {8'h40 + 8'(i), 8'h30 + 8'(i),
                             8'h20 + 8'(i), 8'h10 + 8'(i)});
        push_st(1'b1, 1'b0, 5'd16);
        begin_load();
        send_byte(8'h10);
        send_byte(8'h00);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h10 + 8'(i));
            send_byte(8'h20 + 8'(i));
            send_byte(8'h30 + 8'(i));
            send_byte(8'h40 + 8'(i));
        end
        end_frame();
        drain("full_mem");

        // Reset after five data bytes, then a fresh one-word load.
        push_wr(4'd0, 32'h4433_2211);
        begin_load();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk_reset_vals();
        reset = 1'b0;
        push_wr(4'd0, 32'hDEAD_BEEF);
        push_st(1'b1, 1'b0, 5'd1);
        begin_load();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE);
        send_byte(8'hAD); send_byte(8'hDE);
        end_frame();
        drain("after_reset");

`ifdef PROG_LOADER_CHECKSUM_EN
        push_wr(4'd0, 32'h1234_5678);
        push_st(1'b1, 1'b0, 5'd1);
        begin_load();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56);
        send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h09);
        drain("csum_good");

        push_wr(4'd0, 32'h1234_5678);
        push_st(1'b0, 1'b1, 5'd1);
        begin_load();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56);
        send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h08);
        drain("csum_bad");
`endif

        chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
        chk("st_q_empty", 64'(st_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
